// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inst_sequencer
// Brief    : Moore FSM that fetches, decodes, executes and writes back one instruction at a time.
// Revision : 1.0 - initial release
// ============================================================================
module inst_sequencer #(
   parameter int PC_W     = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_data,
   output logic [31:0]     ir,
   output logic            rf_re,
   output logic            alu_en,
   output logic            rf_we,
   output logic            busy,
   output logic            halted,
   output logic            fault,
   output logic [15:0]     retired
);

   localparam int                 WAIT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
   localparam logic [31:0]        HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [15:0]       retired_q, retired_d;
   logic              retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      retire    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            // An ack arriving on the last allowed cycle still wins over the timeout.
            if (imem_ack) begin
               ir_d    = imem_data;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_MAX) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: state_d = (ir_q == HALT_WORD) ? S_HALT : S_EXEC;
         S_EXEC: begin
            if (ir_q[18:15] != 4'b0000) state_d = S_WB;
            else                        retire  = 1'b1;
         end
         S_WB:    retire  = 1'b1;
         S_HALT:  state_d = S_HALT;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         state_d = S_FETCH;
         wait_d  = '0;
         pc_d    = pc_q + 1'b1;
         if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
      end
   end

   always_comb begin
      imem_req = (state_q == S_FETCH);
      rf_re    = (state_q == S_DECODE);
      alu_en   = (state_q == S_EXEC);
      rf_we    = (state_q == S_WB);
      halted   = (state_q == S_HALT);
      fault    = (state_q == S_ERR);
      busy     = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
   end

   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_sequencer
// Brief    : Self-checking bench for inst_sequencer against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_sequencer;

   localparam int PC_W     = 8;
   localparam int MAX_WAIT = 15;

   logic            clk;
   logic            reset;
   logic            start;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_data;
   logic [31:0]     ir;
   logic            rf_re;
   logic            alu_en;
   logic            rf_we;
   logic            busy;
   logic            halted;
   logic            fault;
   logic [15:0]     retired;

   int          total = 0;
   int          bad   = 0;
   int          m_pc;
   int          m_ret;
   logic [31:0] m_ir;
   logic [6:0]  obs;

   inst_sequencer #(.PC_W(PC_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .ir        (ir),
      .rf_re     (rf_re),
      .alu_en    (alu_en),
      .rf_we     (rf_we),
      .busy      (busy),
      .halted    (halted),
      .fault     (fault),
      .retired   (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe vector order: {imem_req, rf_re, alu_en, rf_we, busy, halted, fault}
   assign obs = {imem_req, rf_re, alu_en, rf_we, busy, halted, fault};

   function automatic logic [31:0] rand_word(input bit nop);
      logic [31:0] w;
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
      if (nop) w[18:15] = 4'b0000;
      return w;
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      start     = 1'($urandom_range(0, 1));
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      @(negedge clk);
      reset    = 1'b0;
      start    = 1'b0;
      imem_ack = 1'b0;
      m_pc     = 0;
      m_ret    = 0;
      m_ir     = 32'h0;
   endtask

   task automatic go();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at a negedge with the DUT in its first FETCH cycle; returns at the next FETCH (or HALT).
   task automatic run_instr(input logic [31:0] w, input int delay);
      for (int k = 0; k <= delay; k++) begin
         total++;
         if (obs !== 7'b1000100 || imem_addr !== PC_W'(m_pc) || ir !== m_ir) begin
            bad++;
            $display("FAIL fetch k=%0d: got strobes=%b addr=%0d ir=%h, want strobes=1000100 addr=%0d ir=%h",
                     k, obs, imem_addr, ir, m_pc, m_ir);
         end
         imem_ack  = (k == delay);
         imem_data = (k == delay) ? w : $urandom;
         @(negedge clk);
      end
      m_ir      = w;
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      total++;
      if (obs !== 7'b0100100 || ir !== m_ir) begin
         bad++;
         $display("FAIL decode: got strobes=%b ir=%h, want strobes=0100100 ir=%h", obs, ir, m_ir);
      end
      @(negedge clk);
      if (w == 32'hFFFF_FFFF) begin
         imem_ack = 1'b0;
         total++;
         if (obs !== 7'b0000010 || ir !== m_ir || imem_addr !== PC_W'(m_pc) || retired !== 16'(m_ret)) begin
            bad++;
            $display("FAIL halt: got strobes=%b ir=%h addr=%0d retired=%0d, want strobes=0000010 ir=%h addr=%0d retired=%0d",
                     obs, ir, imem_addr, retired, m_ir, m_pc, m_ret);
         end
         return;
      end
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      total++;
      if (obs !== 7'b0010100 || ir !== m_ir) begin
         bad++;
         $display("FAIL exec: got strobes=%b ir=%h, want strobes=0010100 ir=%h", obs, ir, m_ir);
      end
      @(negedge clk);
      if (w[18:15] != 4'b0000) begin
         imem_ack = 1'($urandom_range(0, 1));
         total++;
         if (obs !== 7'b0001100 || ir !== m_ir) begin
            bad++;
            $display("FAIL wb: got strobes=%b ir=%h, want strobes=0001100 ir=%h", obs, ir, m_ir);
         end
         @(negedge clk);
      end
      imem_ack = 1'b0;
      m_pc     = (m_pc + 1) % (1 << PC_W);
      if (m_ret < 65535) m_ret++;
      total++;
      if (imem_req !== 1'b1 || retired !== 16'(m_ret) || imem_addr !== PC_W'(m_pc)) begin
         bad++;
         $display("FAIL retire: got req=%b retired=%0d addr=%0d, want req=1 retired=%0d addr=%0d",
                  imem_req, retired, imem_addr, m_ret, m_pc);
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         total++;
         if (obs !== 7'b0 || imem_addr !== '0 || ir !== 32'h0 || retired !== 16'h0) begin
            bad++;
            $display("FAIL reset c=%0d: got strobes=%b addr=%0d ir=%h retired=%0d, want all zero",
                     c, obs, imem_addr, ir, retired);
         end
         imem_ack  = 1'($urandom_range(0, 1));
         imem_data = $urandom;
         @(negedge clk);
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_alu_single();
      do_reset();
      go();
      run_instr(32'h0008_8000, 0);
   endtask

   task automatic test_nop();
      do_reset();
      go();
      run_instr(32'h0000_0000, 0);
   endtask

   task automatic test_delayed_ack();
      do_reset();
      go();
      run_instr(rand_word(1'b0), 3);
      run_instr(rand_word(1'b1), 2);
   endtask

   task automatic test_timeout();
      do_reset();
      go();
      for (int k = 0; k <= MAX_WAIT; k++) begin
         total++;
         if (obs !== 7'b1000100 || imem_addr !== '0) begin
            bad++;
            $display("FAIL timeout_wait k=%0d: got strobes=%b addr=%0d, want strobes=1000100 addr=0", k, obs, imem_addr);
         end
         imem_ack  = 1'b0;
         imem_data = $urandom;
         @(negedge clk);
      end
      for (int c = 0; c < 4; c++) begin
         total++;
         if (obs !== 7'b0000001 || ir !== 32'h0 || imem_addr !== '0) begin
            bad++;
            $display("FAIL timeout_err c=%0d: got strobes=%b ir=%h addr=%0d, want strobes=0000001 ir=0 addr=0",
                     c, obs, ir, imem_addr);
         end
         start     = 1'b1;
         imem_ack  = 1'($urandom_range(0, 1));
         imem_data = $urandom;
         @(negedge clk);
      end
      start = 1'b0;
      do_reset();
      total++;
      if (obs !== 7'b0 || retired !== 16'h0) begin
         bad++;
         $display("FAIL reset_from_err: got strobes=%b retired=%0d, want 0 0", obs, retired);
      end
   endtask

   task automatic test_halt();
      do_reset();
      go();
      for (int i = 0; i < 5; i++) run_instr(rand_word(($urandom_range(0, 3) == 0)), $urandom_range(0, 2));
      run_instr(32'hFFFF_FFFF, $urandom_range(0, 3));
      for (int c = 0; c < 3; c++) begin
         start     = 1'b1;
         imem_ack  = 1'($urandom_range(0, 1));
         imem_data = $urandom;
         @(negedge clk);
         total++;
         if (obs !== 7'b0000010 || imem_addr !== PC_W'(5) || retired !== 16'd5) begin
            bad++;
            $display("FAIL halt_hold c=%0d: got strobes=%b addr=%0d retired=%0d, want strobes=0000010 addr=5 retired=5",
                     c, obs, imem_addr, retired);
         end
      end
      start = 1'b0;
      do_reset();
      total++;
      if (obs !== 7'b0 || imem_addr !== '0 || ir !== 32'h0) begin
         bad++;
         $display("FAIL reset_from_halt: got strobes=%b addr=%0d ir=%h, want 0 0 0", obs, imem_addr, ir);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      go();
      for (int i = 0; i < (1 << PC_W); i++) run_instr(rand_word(1'b1), 0);
      total++;
      if (imem_addr !== '0 || retired !== 16'(1 << PC_W)) begin
         bad++;
         $display("FAIL wrap: got addr=%0d retired=%0d, want addr=0 retired=%0d", imem_addr, retired, 1 << PC_W);
      end
   endtask

   task automatic test_reset_in_wb();
      do_reset();
      go();
      imem_ack  = 1'b1;
      imem_data = 32'h0008_8000;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (obs !== 7'b0001100) begin
         bad++;
         $display("FAIL reach_wb: got strobes=%b, want 0001100", obs);
      end
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      total++;
      if (obs !== 7'b0 || imem_addr !== '0 || ir !== 32'h0 || retired !== 16'h0) begin
         bad++;
         $display("FAIL reset_in_wb: got strobes=%b addr=%0d ir=%h retired=%0d, want all zero",
                  obs, imem_addr, ir, retired);
      end
      @(negedge clk);
      total++;
      if (obs !== 7'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got strobes=%b, want 0000000", obs);
      end
   endtask

   task automatic test_random();
      do_reset();
      go();
      for (int i = 0; i < 30; i++) begin
         run_instr(rand_word(($urandom_range(0, 3) == 0)), (i == 5) ? MAX_WAIT : $urandom_range(0, 4));
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      imem_ack  = 1'b0;
      imem_data = 32'h0;
      m_pc      = 0;
      m_ret     = 0;
      m_ir      = 32'h0;
      test_reset();
      test_alu_single();
      test_nop();
      test_delayed_ack();
      test_timeout();
      test_halt();
      test_wrap();
      test_reset_in_wb();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
